// File: rtl/tm1638_responder.sv
// Device-side TM1638 model: decodes stb/sclk/dio frames, holds display RAM and control, returns key bytes.
// Optional framing-error counter built when TM1638_PROTO_ERR_EN is defined.
module tm1638_responder (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic        stb,
  input  logic        sclk,
  input  logic        dio_in,
  output logic        dio_out,
  output logic        dio_oe,
  input  logic [31:0] keys,
  input  logic [3:0]  ram_raddr,
  output logic [7:0]  ram_rdata,
  output logic        disp_on,
  output logic [2:0]  disp_bright,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA, S_IGNORE} state_t;

  state_t      r_state;
  state_t      w_next;

  logic [2:0]  r_stb_s;
  logic [2:0]  r_sclk_s;
  logic [2:0]  r_dio_s;

  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shreg;
  logic [7:0]  r_byte;
  logic        r_byte_vld;

  logic        r_rd;
  logic        r_fixed;
  logic [3:0]  r_addr;
  logic [7:0]  r_ram [16];

  logic [31:0] r_rd_sh;
  logic [5:0]  r_rd_cnt;

  logic        w_stb_fall;
  logic        w_stb_rise;
  logic        w_active;
  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic        w_byte_evt;
  logic        w_rd_enter;

  // stb sync resets low so a frame already in progress at reset is ignored until stb cycles high then low
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      r_stb_s  <= '0;
      r_sclk_s <= '1;
      r_dio_s  <= '1;
    end else begin
      r_stb_s  <= {r_stb_s[1:0], stb};
      r_sclk_s <= {r_sclk_s[1:0], sclk};
      r_dio_s  <= {r_dio_s[1:0], dio_in};
    end
  end

  assign w_stb_fall  = r_stb_s[2] & ~r_stb_s[1];
  assign w_stb_rise  = ~r_stb_s[2] & r_stb_s[1];
  assign w_active    = (r_state != S_IDLE) & ~w_stb_rise & ~w_stb_fall;
  assign w_sclk_rise = w_active & ~r_sclk_s[2] & r_sclk_s[1];
  assign w_sclk_fall = w_active & r_sclk_s[2] & ~r_sclk_s[1];
  assign w_byte_evt  = r_byte_vld & ~w_stb_rise & ~w_stb_fall;

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      r_bitcnt   <= '0;
      r_shreg    <= '0;
      r_byte     <= '0;
      r_byte_vld <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;
      if (w_stb_rise || w_stb_fall) begin
        r_bitcnt <= '0;
      end else if (w_sclk_rise) begin
        r_shreg  <= {r_dio_s[1], r_shreg[7:1]};
        r_bitcnt <= r_bitcnt + 3'd1;
        if (r_bitcnt == 3'd7) begin
          r_byte     <= {r_dio_s[1], r_shreg[7:1]};
          r_byte_vld <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_stb_rise) begin
      w_next = S_IDLE;
    end else if (w_stb_fall) begin
      w_next = S_CMD;
    end else if (w_byte_evt && (r_state == S_CMD)) begin
      case (r_byte[7:6])
        2'b01:   w_next = r_byte[1] ? S_RDATA : S_IGNORE;
        2'b11:   w_next = r_rd ? S_IGNORE : S_WDATA;
        default: w_next = S_IGNORE;
      endcase
    end
  end

  assign w_rd_enter = (w_next == S_RDATA) && (r_state != S_RDATA);

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      r_rd        <= 1'b0;
      r_fixed     <= 1'b0;
      r_addr      <= '0;
      disp_on     <= 1'b0;
      disp_bright <= '0;
      ram_rdata   <= '0;
      for (int unsigned i = 0; i < 16; i++) r_ram[i] <= '0;
    end else begin
      ram_rdata <= r_ram[ram_raddr];
      if (w_byte_evt) begin
        case (r_state)
          S_CMD: begin
            case (r_byte[7:6])
              2'b01: begin
                r_rd    <= r_byte[1];
                r_fixed <= r_byte[2];
              end
              2'b10: begin
                disp_on     <= r_byte[3];
                disp_bright <= r_byte[2:0];
              end
              2'b11:   r_addr <= r_byte[3:0];
              default: ;
            endcase
          end
          S_WDATA: begin
            r_ram[r_addr] <= r_byte;
            if (!r_fixed) r_addr <= r_addr + 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Each sclk fall shifts out the next key bit; once 32 bits are gone the line idles high
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      dio_oe   <= 1'b0;
      dio_out  <= 1'b1;
      r_rd_sh  <= '0;
      r_rd_cnt <= '0;
    end else if (w_stb_rise) begin
      dio_oe  <= 1'b0;
      dio_out <= 1'b1;
    end else if (w_rd_enter) begin
      dio_oe   <= 1'b1;
      dio_out  <= 1'b1;
      r_rd_sh  <= keys;
      r_rd_cnt <= '0;
    end else if ((r_state == S_RDATA) && w_sclk_fall) begin
      if (!r_rd_cnt[5]) begin
        dio_out  <= r_rd_sh[0];
        r_rd_sh  <= {1'b1, r_rd_sh[31:1]};
        r_rd_cnt <= r_rd_cnt + 6'd1;
      end else begin
        dio_out <= 1'b1;
      end
    end
  end

`ifdef TM1638_PROTO_ERR_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else if (w_stb_rise && (r_bitcnt != 3'd0) && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_tm1638_responder.sv
// Directed bench for tm1638_responder: drives controller-side frames, scoreboard queue of expected values.
module tb_tm1638_responder;

  logic        clk_50M = 1'b0;
  logic        reset   = 1'b1;
  logic        stb     = 1'b1;
  logic        sclk    = 1'b1;
  logic        dio_in  = 1'b1;
  logic        dio_out;
  logic        dio_oe;
  logic [31:0] keys      = '0;
  logic [3:0]  ram_raddr = '0;
  logic [7:0]  ram_rdata;
  logic        disp_on;
  logic [2:0]  disp_bright;
  logic [7:0]  err_cnt;

  tm1638_responder dut (
    .clk_50M     (clk_50M),
    .reset       (reset),
    .stb         (stb),
    .sclk        (sclk),
    .dio_in      (dio_in),
    .dio_out     (dio_out),
    .dio_oe      (dio_oe),
    .keys        (keys),
    .ram_raddr   (ram_raddr),
    .ram_rdata   (ram_rdata),
    .disp_on     (disp_on),
    .disp_bright (disp_bright),
    .err_cnt     (err_cnt)
  );

  always #10 clk_50M = ~clk_50M;

  int          n_cmp = 0;
  int          n_mis = 0;
  string       q_tag[$];
  logic [31:0] q_exp[$];

  function automatic void push_exp(input string tag, input logic [31:0] e);
    q_tag.push_back(tag);
    q_exp.push_back(e);
  endfunction

  task automatic compare(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_cmp++;
    assert (q_exp.size() != 0) else begin
      n_mis++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end
    if (q_exp.size() != 0) begin
      t = q_tag.pop_front();
      e = q_exp.pop_front();
      assert (obs === e) else begin
        n_mis++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_50M);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      sclk   = 1'b0;
      dio_in = b[i];
      cyc(5);
      sclk = 1'b1;
      cyc(5);
    end
  endtask

  task automatic frame_begin();
    stb = 1'b0;
    cyc(5);
  endtask

  task automatic frame_end();
    cyc(5);
    stb    = 1'b1;
    dio_in = 1'b1;
    cyc(10);
  endtask

  task automatic send_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2);
    frame_begin();
    send_bits(b0, 8);
    if (n > 1) send_bits(b1, 8);
    if (n > 2) send_bits(b2, 8);
    frame_end();
  endtask

  task automatic check_ram(input logic [3:0] a, input logic [7:0] e);
    push_exp($sformatf("ram%0d", a), {24'h0, e});
    ram_raddr = a;
    cyc(2);
    @(negedge clk_50M);
    compare({24'h0, ram_rdata});
  endtask

  task automatic check_ctrl(input logic on, input logic [2:0] br, input string tag);
    push_exp({tag, "_on"}, {31'h0, on});
    push_exp({tag, "_bright"}, {29'h0, br});
    @(negedge clk_50M);
    compare({31'h0, disp_on});
    compare({29'h0, disp_bright});
  endtask

  logic [31:0] got;

  initial begin
    cyc(10);
    reset = 1'b0;
    cyc(2);

    check_ctrl(1'b0, 3'd0, "rst");
    push_exp("rst_oe", 32'h0);
    push_exp("rst_dout", 32'h1);
    push_exp("rst_err", 32'h0);
    @(negedge clk_50M);
    compare({31'h0, dio_oe});
    compare({31'h0, dio_out});
    compare({24'h0, err_cnt});
    for (int a = 0; a < 16; a++) check_ram(a[3:0], 8'h00);

    // auto-increment write wrapping 15 -> 0
    send_frame(1, 8'h40, 8'h00, 8'h00);
    send_frame(3, 8'hCF, 8'h3F, 8'h06);
    check_ram(4'd15, 8'h3F);
    check_ram(4'd0, 8'h06);
    check_ram(4'd1, 8'h00);

    // fixed-address write
    send_frame(1, 8'h44, 8'h00, 8'h00);
    send_frame(3, 8'hC3, 8'hAA, 8'h55);
    check_ram(4'd3, 8'h55);
    check_ram(4'd4, 8'h00);

    send_frame(1, 8'h8D, 8'h00, 8'h00);
    check_ctrl(1'b1, 3'd5, "dc8d");
    send_frame(1, 8'h80, 8'h00, 8'h00);
    check_ctrl(1'b0, 3'd0, "dc80");

    // partial byte: five bits of 0xC3 then stb high
    frame_begin();
    send_bits(8'hC3, 5);
    frame_end();
`ifdef TM1638_PROTO_ERR_EN
    push_exp("partial_err", 32'h1);
`else
    push_exp("partial_err", 32'h0);
`endif
    @(negedge clk_50M);
    compare({24'h0, err_cnt});
    check_ram(4'd3, 8'h55);
    check_ram(4'd0, 8'h06);
    send_frame(2, 8'hC7, 8'h11, 8'h00);
    check_ram(4'd7, 8'h11);
    check_ram(4'd8, 8'h00);

    // key read, keys changed mid-read
    keys = 32'h8040_2001;
    frame_begin();
    send_bits(8'h42, 8);
    dio_in = 1'b1;
    cyc(5);
    push_exp("rd_oe", 32'h1);
    push_exp("rd_byte0", 32'h01);
    push_exp("rd_byte1", 32'h20);
    push_exp("rd_byte2", 32'h40);
    push_exp("rd_byte3", 32'h80);
    push_exp("rd_idle_high", 32'h1);
    push_exp("rd_oe_release", 32'h0);
    got = '0;
    for (int i = 0; i < 32; i++) begin
      sclk = 1'b0;
      cyc(5);
      @(negedge clk_50M);
      got[i] = dio_out;
      if (i == 8) keys = 32'h0;
      if (i == 16) compare({31'h0, dio_oe});
      cyc(1);
      sclk = 1'b1;
      cyc(5);
    end
    compare({24'h0, got[7:0]});
    compare({24'h0, got[15:8]});
    compare({24'h0, got[23:16]});
    compare({24'h0, got[31:24]});
    sclk = 1'b0;
    cyc(5);
    @(negedge clk_50M);
    compare({31'h0, dio_out});
    cyc(1);
    sclk = 1'b1;
    cyc(5);
    stb = 1'b1;
    cyc(4);
    @(negedge clk_50M);
    compare({31'h0, dio_oe});
    cyc(10);

    // reset in the middle of a WDATA byte; rest of that frame must be ignored
    send_frame(1, 8'h40, 8'h00, 8'h00);
    frame_begin();
    send_bits(8'hC2, 8);
    send_bits(8'h77, 4);
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    send_bits(8'h07, 4);
    send_bits(8'h99, 8);
    frame_end();
    for (int a = 0; a < 16; a++) check_ram(a[3:0], 8'h00);
    push_exp("mrst_err", 32'h0);
    @(negedge clk_50M);
    compare({24'h0, err_cnt});
    send_frame(3, 8'hC5, 8'h9A, 8'hBC);
    check_ram(4'd5, 8'h9A);
    check_ram(4'd6, 8'hBC);
    check_ram(4'd7, 8'h00);

    n_cmp++;
    assert (q_exp.size() == 0) else begin
      n_mis++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", q_exp.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
